// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the row-cache / output-array SRAM responder:
//   - region codes carried in address_sram[25:13]
//   - access mode and write-source encodings
//   - upper bound on the configurable read latency
//   - in_range(): offset-versus-depth check used by the region decoder
// -----------------------------------------------------------------------------
package sram_pkg;

  localparam logic [12:0] REGION_ROWCACHE  = 13'd0;
  localparam logic [12:0] REGION_OUTPUT    = 13'd1;
  localparam int          MAX_READ_LATENCY = 4;

  typedef enum logic {
    SRAM_READ  = 1'b0,
    SRAM_WRITE = 1'b1
  } sram_mode_t;

  typedef enum logic {
    SRC_SDRAM  = 1'b0,
    SRC_FILTER = 1'b1
  } sram_src_t;

  // True when a 13-bit offset addresses an existing word of a bank of 'depth' words.
  function automatic logic in_range(input logic [12:0] offset, input int unsigned depth);
    logic [31:0] off_w;
    off_w = {19'd0, offset};
    return (off_w < depth);
  endfunction

endpackage

// File: rtl/sram_bank.sv
// -----------------------------------------------------------------------------
// sram_bank
// Single-port 32-bit storage array of DEPTH words.
//   - write: mem[addr_i] <= wdata_i on the clock edge where we_i is high
//   - read : rdata_o registers mem[addr_i] on the edge where re_i is high and
//            holds that value until the next read
// Array contents are never cleared; rst_i only clears the read register.
// Ports:
//   clk_i    in   1      clock
//   rst_i    in   1      synchronous active-high reset (read register only)
//   we_i     in   1      write enable
//   re_i     in   1      read enable
//   addr_i   in   AW     word address
//   wdata_i  in   32     write data
//   rdata_o  out  32     registered read data
// -----------------------------------------------------------------------------
module sram_bank #(
  parameter int DEPTH = 8192,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Storage array write port (no reset: contents survive rst).
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= 32'd0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/row_cache_sram.sv
// -----------------------------------------------------------------------------
// row_cache_sram
// On-chip responder for the custom-logic SRAM port. Holds the row cache
// (region 0) and the output array (region 1) in two sram_bank instances.
//   - write (sram_en & mode_sram): data from SDRAM path or filter path
//     (addrCalc_mode_sram) stored at that edge; no response
//   - read  (sram_en & ~mode_sram): bank sampled at the issue edge, result
//     presented on data_sram with a one-cycle sram_datareadvalid pulse
//     READ_LATENCY edges after the issue edge; fully pipelined, in order
//   - unmapped region or offset beyond depth: write dropped, read returns 0,
//     addr_err set and held until rst
// Optional feature: define SRAM_STATS_EN to add rd_count / wr_count ports
// (accepted accesses including errored ones, cleared by rst, wrap at 2^32).
// Ports:
//   clk                 in   1    system clock
//   rst                 in   1    synchronous active-high reset
//   sram_en             in   1    request strobe
//   mode_sram           in   1    0=read, 1=write
//   addrCalc_mode_sram  in   1    write source: 0=SDRAM, 1=filter
//   address_sram        in   26   {region[12:0], offset[12:0]}
//   sram_dataFromSDRAM  in   32   row-cache fill data
//   postFilterData      in   32   filtered pixel data
//   data_sram           out  32   read data, held between reads
//   sram_datareadvalid  out  1    one pulse per completed read
//   rd_count, wr_count  out  32   access counters (SRAM_STATS_EN only)
//   addr_err            out  1    sticky address error
// -----------------------------------------------------------------------------
module row_cache_sram
  import sram_pkg::*;
#(
  parameter int ROW_DEPTH    = 8192,
  parameter int OUT_DEPTH    = 8192,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_en,
  input  logic        mode_sram,
  input  logic        addrCalc_mode_sram,
  input  logic [25:0] address_sram,
  input  logic [31:0] sram_dataFromSDRAM,
  input  logic [31:0] postFilterData,
  output logic [31:0] data_sram,
  output logic        sram_datareadvalid,
`ifdef SRAM_STATS_EN
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
`endif
  output logic        addr_err
);

  localparam int ROW_AW = $clog2(ROW_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [12:0]       region_s;
  logic [12:0]       offset_s;
  sram_mode_t        mode_s;
  sram_src_t         src_s;
  logic              acc_s;
  logic              rd_s;
  logic              wr_s;
  logic              row_hit_s;
  logic              out_hit_s;
  logic              bad_s;
  logic [31:0]       wdata_s;
  logic [ROW_AW-1:0] row_addr_s;
  logic [OUT_AW-1:0] out_addr_s;

  // Region/offset decode, range check, write-source select.
  always_comb begin
    region_s   = address_sram[25:13];
    offset_s   = address_sram[12:0];
    mode_s     = sram_mode_t'(mode_sram);
    src_s      = sram_src_t'(addrCalc_mode_sram);
    acc_s      = sram_en && !rst;
    rd_s       = acc_s && (mode_s == SRAM_READ);
    wr_s       = acc_s && (mode_s == SRAM_WRITE);
    row_hit_s  = (region_s == REGION_ROWCACHE) && in_range(offset_s, ROW_DEPTH);
    out_hit_s  = (region_s == REGION_OUTPUT)   && in_range(offset_s, OUT_DEPTH);
    bad_s      = acc_s && !(row_hit_s || out_hit_s);
    wdata_s    = 32'd0;
    row_addr_s = '0;
    out_addr_s = '0;
    if (src_s == SRC_FILTER) begin
      wdata_s = postFilterData;
    end else begin
      wdata_s = sram_dataFromSDRAM;
    end
    // Offsets are only narrowed to bank width once they are known to be in range.
    if (row_hit_s) begin
      row_addr_s = offset_s[ROW_AW-1:0];
    end else begin
      row_addr_s = '0;
    end
    if (out_hit_s) begin
      out_addr_s = offset_s[OUT_AW-1:0];
    end else begin
      out_addr_s = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage banks
  // ---------------------------------------------------------------------------
  logic [31:0] row_rdata_s;
  logic [31:0] out_rdata_s;

  sram_bank #(.DEPTH(ROW_DEPTH), .AW(ROW_AW)) u_row_bank (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_s && row_hit_s),
    .re_i    (rd_s && row_hit_s),
    .addr_i  (row_addr_s),
    .wdata_i (wdata_s),
    .rdata_o (row_rdata_s)
  );

  sram_bank #(.DEPTH(OUT_DEPTH), .AW(OUT_AW)) u_out_bank (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_s && out_hit_s),
    .re_i    (rd_s && out_hit_s),
    .addr_i  (out_addr_s),
    .wdata_i (wdata_s),
    .rdata_o (out_rdata_s)
  );

  // ---------------------------------------------------------------------------
  // Read pipeline. Stage 0 is aligned with the banks' registered read data;
  // it carries which bank to pick and whether the read was errored.
  // ---------------------------------------------------------------------------
  logic        s0_valid_q;
  logic        s0_sel_q;
  logic        s0_err_q;
  logic [31:0] mux_data_s;
  logic        tail_valid_s;
  logic [31:0] tail_data_s;

  // Stage 0 control register; cleared by rst so in-flight reads are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_sel_q   <= 1'b0;
      s0_err_q   <= 1'b0;
    end else begin
      s0_valid_q <= rd_s;
      s0_sel_q   <= out_hit_s;
      s0_err_q   <= !(row_hit_s || out_hit_s);
    end
  end

  // Bank select; an errored read returns zero regardless of bank contents.
  always_comb begin
    mux_data_s = 32'd0;
    if (s0_err_q) begin
      mux_data_s = 32'd0;
    end else if (s0_sel_q) begin
      mux_data_s = out_rdata_s;
    end else begin
      mux_data_s = row_rdata_s;
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign tail_valid_s = s0_valid_q;
      assign tail_data_s  = mux_data_s;
    end else begin : g_latn
      localparam int NST = READ_LATENCY - 1;
      logic [NST-1:0] dv_q;
      logic [31:0]    dd_q [NST];

      // Valid shift register; flushed by rst.
      always_ff @(posedge clk) begin
        if (rst) begin
          dv_q <= '0;
        end else begin
          dv_q[0] <= s0_valid_q;
          for (int k = 1; k < NST; k++) begin
            dv_q[k] <= dv_q[k-1];
          end
        end
      end

      // Data shift register; only meaningful where the matching valid bit is set.
      always_ff @(posedge clk) begin
        dd_q[0] <= mux_data_s;
        for (int k = 1; k < NST; k++) begin
          dd_q[k] <= dd_q[k-1];
        end
      end

      assign tail_valid_s = dv_q[NST-1];
      assign tail_data_s  = dd_q[NST-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output registers and sticky error flag
  // ---------------------------------------------------------------------------
  logic        valid_q;
  logic [31:0] data_q;
  logic [31:0] data_d;
  logic        addr_err_q;
  logic        addr_err_d;

  // data_sram only changes on a valid cycle, otherwise holds the last read.
  always_comb begin
    data_d     = data_q;
    addr_err_d = addr_err_q;
    if (tail_valid_s) begin
      data_d = tail_data_s;
    end else begin
      data_d = data_q;
    end
    if (bad_s) begin
      addr_err_d = 1'b1;
    end else begin
      addr_err_d = addr_err_q;
    end
  end

  // Output and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      data_q     <= 32'd0;
      addr_err_q <= 1'b0;
    end else begin
      valid_q    <= tail_valid_s;
      data_q     <= data_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign sram_datareadvalid = valid_q;
  assign data_sram          = data_q;
  assign addr_err           = addr_err_q;

`ifdef SRAM_STATS_EN
  logic [31:0] rd_count_q;
  logic [31:0] wr_count_q;

  // Accepted-access counters, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
    end else begin
      if (rd_s) begin
        rd_count_q <= rd_count_q + 32'd1;
      end
      if (wr_s) begin
        wr_count_q <= wr_count_q + 32'd1;
      end
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_row_cache_sram.sv
module tb_row_cache_sram;

  localparam int L  = 2;
  localparam int RD = 8192;
  localparam int OD = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic        sram_en;
  logic        mode_sram;
  logic        addrCalc_mode_sram;
  logic [25:0] address_sram;
  logic [31:0] sram_dataFromSDRAM;
  logic [31:0] postFilterData;
  logic [31:0] data_sram;
  logic        sram_datareadvalid;
  logic        addr_err;
`ifdef SRAM_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  always #5 clk = ~clk;

  row_cache_sram #(.ROW_DEPTH(RD), .OUT_DEPTH(OD), .READ_LATENCY(L)) dut (
    .clk                (clk),
    .rst                (rst),
    .sram_en            (sram_en),
    .mode_sram          (mode_sram),
    .addrCalc_mode_sram (addrCalc_mode_sram),
    .address_sram       (address_sram),
    .sram_dataFromSDRAM (sram_dataFromSDRAM),
    .postFilterData     (postFilterData),
    .data_sram          (data_sram),
    .sram_datareadvalid (sram_datareadvalid),
`ifdef SRAM_STATS_EN
    .rd_count           (rd_count),
    .wr_count           (wr_count),
`endif
    .addr_err           (addr_err)
  );

  // Reference model: two word arrays, a queue of outstanding reads stamped with
  // their issue edge, and the expected output state.
  typedef struct {
    int          issue;
    logic [31:0] data;
  } rd_t;

  logic [31:0] m_row [RD];
  logic [31:0] m_out [OD];
  rd_t         rq[$];
  logic        exp_v;
  logic [31:0] exp_d;
  logic        exp_e;
  int unsigned m_rd;
  int unsigned m_wr;
  int          edge_n;
  int unsigned passed;
  int unsigned fails;
  int unsigned total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_n, obs, expv);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check #1 later.
  task automatic cyc(input logic r, input logic en, input logic md, input logic src,
                     input logic [25:0] a, input logic [31:0] ds, input logic [31:0] df);
    logic [12:0] region;
    logic [12:0] off;
    logic        ok_row;
    logic        ok_out;
    logic [31:0] d;
    rst = r; sram_en = en; mode_sram = md; addrCalc_mode_sram = src;
    address_sram = a; sram_dataFromSDRAM = ds; postFilterData = df;
    @(posedge clk);
    edge_n++;
    if (r) begin
      rq.delete();
      exp_v = 1'b0; exp_d = 32'd0; exp_e = 1'b0; m_rd = 0; m_wr = 0;
    end else begin
      exp_v = 1'b0;
      if (rq.size() > 0 && rq[0].issue + L == edge_n) begin
        exp_v = 1'b1;
        exp_d = rq[0].data;
        void'(rq.pop_front());
      end
      if (en) begin
        region = a[25:13];
        off    = a[12:0];
        ok_row = (region == 13'd0) && (int'(off) < RD);
        ok_out = (region == 13'd1) && (int'(off) < OD);
        if (!(ok_row || ok_out)) exp_e = 1'b1;
        if (md) begin
          m_wr++;
          d = src ? df : ds;
          if (ok_row) m_row[off] = d;
          else if (ok_out) m_out[off] = d;
        end else begin
          m_rd++;
          d = ok_row ? m_row[off] : (ok_out ? m_out[off] : 32'd0);
          rq.push_back('{edge_n, d});
        end
      end
    end
    #1;
    chk("valid", {31'd0, sram_datareadvalid}, {31'd0, exp_v});
    chk("data",  data_sram, exp_d);
    chk("err",   {31'd0, addr_err}, {31'd0, exp_e});
`ifdef SRAM_STATS_EN
    chk("rd_count", rd_count, m_rd);
    chk("wr_count", wr_count, m_wr);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 26'd0, 32'd0, 32'd0);
  endtask

  task automatic wr(input logic src, input logic [12:0] reg_, input logic [12:0] off, input logic [31:0] d);
    cyc(1'b0, 1'b1, 1'b1, src, {reg_, off}, src ? 32'hBAD0_BAD0 : d, src ? d : 32'hBAD1_BAD1);
  endtask

  task automatic rd(input logic [12:0] reg_, input logic [12:0] off);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, {reg_, off}, $urandom, $urandom);
  endtask

  initial begin
    logic [12:0] rreg;
    logic [12:0] roff;
    int unsigned pick;
    passed = 0; fails = 0; total = 0; edge_n = 0;
    m_rd = 0; m_wr = 0; exp_v = 1'b0; exp_d = 32'd0; exp_e = 1'b0;

    // Reset state.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 26'd0, 32'd0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 26'd0, 32'd0, 32'd0);

    // Preload offsets 0..15 of both banks with ramps.
    for (int i = 0; i < 16; i++) wr(1'b0, 13'd0, 13'(i), 32'h1000_0000 + 32'(i));
    for (int i = 0; i < 16; i++) wr(1'b1, 13'd1, 13'(i), 32'h2000_0000 + 32'(i));

    // Write from SDRAM path, read back after READ_LATENCY edges.
    wr(1'b0, 13'd0, 13'd5, 32'hDEAD_BEEF);
    rd(13'd0, 13'd5);
    idle(L + 1);

    // Filter-path write to output bank; regions stay isolated.
    wr(1'b1, 13'd1, 13'd7, 32'h00FF_00FF);
    rd(13'd0, 13'd7);
    rd(13'd1, 13'd7);
    idle(L + 1);

    // Back-to-back reads of the row ramp.
    for (int i = 8; i < 16; i++) rd(13'd0, 13'(i));
    idle(L + 1);

    // Randomized traffic on mapped addresses.
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 9);
      rreg = 13'($urandom_range(0, 1));
      roff = 13'($urandom_range(0, 15));
      if (pick < 3) wr(1'($urandom_range(0, 1)), rreg, roff, $urandom);
      else if (pick < 8) rd(rreg, roff);
      else idle(1);
    end
    idle(L + 1);

    // Unmapped region: read returns 0 with valid, error sticks, write dropped.
    rd(13'd2, 13'd0);
    idle(L + 2);
    wr(1'b0, 13'd2, 13'd0, 32'h5555_AAAA);
    rd(13'd0, 13'd0);
    rd(13'd1, 13'd0);
    rd(13'($urandom_range(3, 8191)), 13'($urandom_range(0, 8191)));
    idle(L + 1);

    // Reset while reads are in flight; contents survive reset.
    rd(13'd0, 13'd1);
    rd(13'd0, 13'd2);
    rd(13'd1, 13'd3);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 26'd0, 32'd0, 32'd0);
    idle(L + 2);
    rd(13'd1, 13'd3);
    idle(L + 1);

    // Random mix including unmapped addresses, then a clean drain.
    for (int i = 0; i < 200; i++) begin
      pick = $urandom_range(0, 9);
      rreg = (pick == 9) ? 13'($urandom_range(2, 8191)) : 13'($urandom_range(0, 1));
      roff = 13'($urandom_range(0, 15));
      if (pick < 4) wr(1'($urandom_range(0, 1)), rreg, roff, $urandom);
      else rd(rreg, roff);
    end
    idle(L + 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
